// File: rtl/icap_bitstream_packer_if.sv
// Stream-in / FIFO-out bundle for the ICAP bitstream packer.
// slave  : the packer's view (consumes the stream, drives the FIFO write side).
// master : the surrounding system's view (drives the stream, observes FIFO writes).
interface icap_bitstream_packer_if;
    logic [63:0]  s_tdata;
    logic [7:0]   s_tkeep;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic         fifo_full;
    logic [255:0] fifo_data;
    logic         fifo_write_en;

    modport slave (
        input  s_tdata,
        input  s_tkeep,
        input  s_tvalid,
        input  s_tlast,
        input  fifo_full,
        output s_tready,
        output fifo_data,
        output fifo_write_en
    );

    modport master (
        output s_tdata,
        output s_tkeep,
        output s_tvalid,
        output s_tlast,
        output fifo_full,
        input  s_tready,
        input  fifo_data,
        input  fifo_write_en
    );
endinterface

// File: rtl/icap_bitstream_packer.sv
// Packs a 64-bit bitstream stream into 256-bit configuration FIFO entries.
// Beat n of an entry lands in lane n (fifo_data[64n+63:64n]), so the earliest
// ICAP word sits in fifo_data[31:0]. A short final entry is filled out with
// Type-1 NOOP words so the ICAP engine never consumes undefined data.
module icap_bitstream_packer #(
    parameter int          IN_DATA_SIZE = 64,
    parameter int          DATA_SIZE    = 256,
    parameter int          FLAG_SIZE    = 1,
    parameter logic [31:0] PAD_WORD     = 32'h20000000,
    parameter int          CNT_SIZE     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    icap_bitstream_packer_if.slave bus,
    output logic                   frame_done,
    output logic [CNT_SIZE-1:0]    entry_count,
    output logic                   protocol_err
);

    localparam int LANES  = DATA_SIZE / IN_DATA_SIZE;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    state_t                                 state_q, state_d;
    logic [LANE_W-1:0]                      lane_cnt_q, lane_cnt_d;
    logic [LANES-1:0][IN_DATA_SIZE-1:0]     data_q, data_d;
    logic [FLAG_SIZE-1:0]                   last_flag_q, last_flag_d;
    logic [FLAG_SIZE-1:0]                   protocol_err_q, protocol_err_d;
    logic [CNT_SIZE-1:0]                    entry_count_q, entry_count_d;

    logic                    s_tready_int;
    logic                    beat_accept;
    logic                    pad_upper;
    logic                    keep_illegal;
    logic [IN_DATA_SIZE-1:0] beat_word;

    // Ready only in FILL; gated by reset so the upstream sees ready low while reset is held.
    assign s_tready_int = (state_q == S_FILL) && reset;
    assign beat_accept  = bus.s_tvalid && s_tready_int;

    // A half-kept beat is only meaningful as the final beat; anything else is a full beat plus an error.
    assign pad_upper    = bus.s_tlast && (bus.s_tkeep == 8'h0F);
    assign keep_illegal = !((bus.s_tkeep == 8'hFF) || pad_upper);
    assign beat_word    = pad_upper ? {PAD_WORD, bus.s_tdata[31:0]} : bus.s_tdata;

    // Per-lane next value: the current lane takes the beat; on a last beat every higher lane is padded.
    // Every lane is rewritten before an entry completes, so no stale data from a prior entry survives.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign data_d[gi] = !beat_accept                                  ? data_q[gi] :
                            (lane_cnt_q == LANE_W'(gi))                   ? beat_word :
                            (bus.s_tlast && (int'(lane_cnt_q) < gi))      ? {PAD_WORD, PAD_WORD} :
                                                                            data_q[gi];
    end

    // State register and datapath flops; reset discards any partially packed entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_FILL;
            lane_cnt_q     <= '0;
            data_q         <= '0;
            last_flag_q    <= '0;
            protocol_err_q <= '0;
            entry_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            lane_cnt_q     <= lane_cnt_d;
            data_q         <= data_d;
            last_flag_q    <= last_flag_d;
            protocol_err_q <= protocol_err_d;
            entry_count_q  <= entry_count_d;
        end
    end

    // Next-state and write-strobe logic: FILL collects beats, HOLD presents the entry until the FIFO takes it.
    always_comb begin
        state_d           = state_q;
        lane_cnt_d        = lane_cnt_q;
        last_flag_d       = last_flag_q;
        protocol_err_d    = protocol_err_q;
        entry_count_d     = entry_count_q;
        bus.fifo_write_en = 1'b0;
        frame_done        = 1'b0;

        case (state_q)
            S_FILL: begin
                if (beat_accept) begin
                    if (keep_illegal) begin
                        protocol_err_d = FLAG_SIZE'(1);
                    end
                    if ((lane_cnt_q == LAST_LANE) || bus.s_tlast) begin
                        state_d     = S_HOLD;
                        lane_cnt_d  = '0;
                        last_flag_d = FLAG_SIZE'(bus.s_tlast);
                    end else begin
                        lane_cnt_d = lane_cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!bus.fifo_full) begin
                    bus.fifo_write_en = 1'b1;
                    state_d           = S_FILL;
                    if (last_flag_q[0]) begin
                        frame_done    = 1'b1;
                        entry_count_d = '0;
                        last_flag_d   = '0;
                    end else begin
                        entry_count_d = entry_count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    assign bus.s_tready  = s_tready_int;
    assign bus.fifo_data = data_q;
    assign entry_count   = entry_count_q;
    assign protocol_err  = protocol_err_q[0];

endmodule

// File: tb/tb_icap_bitstream_packer.sv
// Directed bench for icap_bitstream_packer: packing order, NOOP padding,
// FIFO back-pressure, keep errors, reset behaviour and long randomised-gap streams.
module tb_icap_bitstream_packer;

    localparam logic [31:0] PAD  = 32'h20000000;
    localparam logic [63:0] PAD2 = {PAD, PAD};

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_done;
    logic [15:0] entry_count;
    logic        protocol_err;

    int tests  = 0;
    int fails  = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;

    icap_bitstream_packer_if bus();

    icap_bitstream_packer dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .frame_done   (frame_done),
        .entry_count  (entry_count),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    // Count FIFO writes and frame completions at the sampling edge.
    always @(negedge clock) begin
        if (bus.fifo_write_en) wr_cnt++;
        if (frame_done)        fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int   n  = 0;
        logic ok = 1'b0;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        bus.s_tkeep  = k;
        bus.s_tlast  = l;
        while (!ok && n < 100) begin
            @(negedge clock);
            ok = bus.s_tready;
            @(posedge clock);
            #1;
            n++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    // Wait (bounded) for one FIFO write and check its payload and frame_done.
    task automatic expect_write(input string tag, input logic [255:0] ed, input logic efd, input int max_wait);
        int   n    = 0;
        logic seen = 1'b0;
        logic [255:0] d_obs;
        logic         fd_obs;
        while (!seen && n < max_wait) begin
            @(negedge clock);
            seen   = bus.fifo_write_en;
            d_obs  = bus.fifo_data;
            fd_obs = frame_done;
            if (!seen) begin
                @(posedge clock);
                #1;
            end
            n++;
        end
        chk({tag, "_write"}, seen, 1);
        if (seen) begin
            chk({tag, "_data"}, d_obs, ed);
            chk({tag, "_frame_done"}, fd_obs, efd);
            tick();
        end
    endtask

    initial begin
        logic [63:0]  d [12];
        logic [255:0] exp_entry;
        logic [63:0]  rd;
        int           base;
        int           fd_base;

        bus.s_tvalid  = 1'b0;
        bus.s_tdata   = '0;
        bus.s_tkeep   = 8'hFF;
        bus.s_tlast   = 1'b0;
        bus.fifo_full = 1'b0;
        reset         = 1'b1;
        #1 reset      = 1'b0;
        tick();

        // Reset state
        chk("rst_tready",   bus.s_tready, 0);
        chk("rst_wr_en",    bus.fifo_write_en, 0);
        chk("rst_data",     bus.fifo_data, 0);
        chk("rst_fdone",    frame_done, 0);
        chk("rst_count",    entry_count, 0);
        chk("rst_perr",     protocol_err, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_tready", bus.s_tready, 1);

        // Test 1: four full beats, last on the fourth
        for (int i = 0; i < 4; i++) d[i] = {32'hA000_0001 + 32'(2 * i), 32'hA000_0000 + 32'(2 * i)};
        for (int i = 0; i < 4; i++) send(d[i], 8'hFF, i == 3);
        expect_write("t1", {d[3], d[2], d[1], d[0]}, 1, 1);
        chk("t1_count", entry_count, 0);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_fd_cnt", fd_cnt, 1);

        // Test 2: six beats, last beat half-kept
        for (int i = 0; i < 6; i++) d[i] = {32'hB100_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
        d[5] = 64'hDEADBEEF_B0000005;
        for (int i = 0; i < 4; i++) send(d[i], 8'hFF, 1'b0);
        expect_write("t2a", {d[3], d[2], d[1], d[0]}, 0, 1);
        chk("t2_count1", entry_count, 1);
        send(d[4], 8'hFF, 1'b0);
        send(d[5], 8'h0F, 1'b1);
        rd = d[5];
        expect_write("t2b", {PAD2, PAD2, PAD, rd[31:0], d[4]}, 1, 1);
        chk("t2_count0", entry_count, 0);
        chk("t2_perr", protocol_err, 0);

        // Test 3: FIFO full for 10 cycles while holding, 12 beats in total
        for (int i = 0; i < 12; i++) d[i] = {32'hC100_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
        base = wr_cnt;
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) send(d[i], 8'hFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t3_hold_tready", bus.s_tready, 0);
            chk("t3_hold_wr_en",  bus.fifo_write_en, 0);
            chk("t3_hold_data",   bus.fifo_data, {d[3], d[2], d[1], d[0]});
            @(posedge clock);
            #1;
        end
        bus.fifo_full = 1'b0;
        expect_write("t3a", {d[3], d[2], d[1], d[0]}, 0, 1);
        for (int i = 4; i < 8; i++) send(d[i], 8'hFF, 1'b0);
        expect_write("t3b", {d[7], d[6], d[5], d[4]}, 0, 1);
        for (int i = 8; i < 12; i++) send(d[i], 8'hFF, i == 11);
        expect_write("t3c", {d[11], d[10], d[9], d[8]}, 1, 1);
        chk("t3_writes", wr_cnt - base, 3);
        chk("t3_count", entry_count, 0);

        // Test 4: half-kept beat without last is an error but packs as a full beat
        for (int i = 0; i < 6; i++) d[i] = {32'hD100_0000 + 32'(i), 32'hD000_0000 + 32'(i)};
        send(d[0], 8'hFF, 1'b0);
        send(d[1], 8'h0F, 1'b0);
        send(d[2], 8'hFF, 1'b0);
        send(d[3], 8'hFF, 1'b1);
        expect_write("t4", {d[3], d[2], d[1], d[0]}, 1, 1);
        chk("t4_perr", protocol_err, 1);
        send(d[4], 8'hFF, 1'b1);
        expect_write("t4_single", {PAD2, PAD2, PAD2, d[4]}, 1, 1);
        chk("t4_perr_sticky", protocol_err, 1);
        send(d[5], 8'h00, 1'b1);
        expect_write("t4_keep0", {PAD2, PAD2, PAD2, d[5]}, 1, 1);

        // Test 5a: reset while holding drops the write immediately
        for (int i = 0; i < 4; i++) d[i] = {32'hE100_0000 + 32'(i), 32'hE000_0000 + 32'(i)};
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) send(d[i], 8'hFF, 1'b0);
        base = wr_cnt;
        #1 bus.fifo_full = 1'b0;
        #1 chk("t5_hold_wr_en", bus.fifo_write_en, 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_wr_en",  bus.fifo_write_en, 0);
        chk("t5_rst_data",   bus.fifo_data, 0);
        chk("t5_rst_tready", bus.s_tready, 0);
        chk("t5_rst_perr",   protocol_err, 0);
        chk("t5_rst_count",  entry_count, 0);
        chk("t5_rst_fdone",  frame_done, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("t5_dropped", wr_cnt - base, 0);

        // Test 5b: reset mid-entry, then a clean entry with no stale lanes
        send(64'h1111_1111_2222_2222, 8'hFF, 1'b0);
        send(64'h3333_3333_4444_4444, 8'hFF, 1'b0);
        reset = 1'b0;
        #2;
        chk("t5b_rst_data",   bus.fifo_data, 0);
        chk("t5b_rst_tready", bus.s_tready, 0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) d[i] = {32'hF100_0000 + 32'(i), 32'hF000_0000 + 32'(i)};
        for (int i = 0; i < 4; i++) send(d[i], 8'hFF, i == 3);
        expect_write("t5b", {d[3], d[2], d[1], d[0]}, 1, 1);
        chk("t5b_count", entry_count, 0);

        // Test 6: two back-to-back 8 KB bitstreams with random idle gaps
        for (int s = 0; s < 2; s++) begin
            fd_base = fd_cnt;
            base    = wr_cnt;
            exp_entry = '0;
            for (int b = 0; b < 1024; b++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    bus.s_tdata = {$urandom, $urandom};
                    bus.s_tkeep = 8'($urandom);
                    bus.s_tlast = 1'($urandom);
                    tick();
                end
                rd = {$urandom, $urandom};
                exp_entry[64 * (b % 4) +: 64] = rd;
                send(rd, 8'hFF, b == 1023);
                if (b % 4 == 3) expect_write("t6", exp_entry, b == 1023, 1);
            end
            chk("t6_frames", fd_cnt - fd_base, 1);
            chk("t6_writes", wr_cnt - base, 256);
            chk("t6_count", entry_count, 0);
        end
        chk("t6_perr", protocol_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
